// File: rtl/throttled_dram_model_pkg.sv
// Shared command encodings, throttle constant, FSM states and the credit update
// used by the throttled DRAM stand-in.
package throttled_dram_model_pkg;

   localparam int DDRCWidth = 3;
   localparam logic [DDRCWidth-1:0] DDR3CMD_Write = 3'd0;
   localparam logic [DDRCWidth-1:0] DDR3CMD_Read  = 3'd1;

   localparam logic [7:0] CreditFull = 8'd100;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   // Saturating credit refill; an issue only happens with a full credit so no underflow.
   function automatic logic [7:0] credit_next(input logic [7:0] credit,
                                              input logic       issue,
                                              input logic [7:0] refill);
      logic [8:0] sum;
      sum = {1'b0, credit} - (issue ? 9'd100 : 9'd0) + {1'b0, refill};
      return (sum > {1'b0, CreditFull}) ? CreditFull : sum[7:0];
   endfunction

endpackage

// File: rtl/throttled_dram_model_fiforam.sv
// First-word-fall-through FIFO on a small register array; shared by the command
// and write-data queues.
module throttled_dram_model_fiforam
   import throttled_dram_model_pkg::*;
#(
   parameter int Width    = 8,
   parameter int DepthLog = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [Width-1:0] InData,
   input  logic             InValid,
   output logic             InAccept,
   output logic [Width-1:0] OutData,
   output logic             OutSend,
   input  logic             OutReady
);

   localparam int Depth = 1 << DepthLog;

   logic [Width-1:0]    mem_q [Depth];
   logic [DepthLog-1:0] wr_ptr_q, rd_ptr_q;
   logic [DepthLog:0]   count_q;
   logic                push, pop;

   assign InAccept = ~count_q[DepthLog];
   assign OutSend  = (count_q != '0);
   assign OutData  = mem_q[rd_ptr_q];
   assign push     = InValid & InAccept;
   assign pop      = OutSend & OutReady;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + {{DepthLog{1'b0}}, push} - {{DepthLog{1'b0}}, pop};
      end
   end

   always_ff @(posedge Clock) begin
      if (push) mem_q[wr_ptr_q] <= InData;
   end

endmodule

// File: rtl/throttled_dram_model.sv
// DRAM stand-in with zero-init sweep, in-order command processing, read latency
// and bandwidth throttling, and a backpressure-safe two-entry read output buffer.
module throttled_dram_model
   import throttled_dram_model_pkg::*;
#(
   parameter int AWidth       = 31,
   parameter int DWidth       = 512,
   parameter int MWidth       = DWidth / 8,
   parameter int AddrShift    = 3,
   parameter int MemDepthLog  = 12,
   parameter int CmdBufDepth  = 8,
   parameter int OutInitLat   = 30,
   parameter int OutBandWidth = 57,
   parameter int TimerWidth   = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [AWidth-1:0]    CommandAddress,
   input  logic [DDRCWidth-1:0] Command,
   input  logic                 CommandValid,
   output logic                 CommandReady,
   input  logic [DWidth-1:0]    DataIn,
   input  logic [MWidth-1:0]    DataInMask,
   input  logic                 DataInValid,
   output logic                 DataInReady,
   output logic [DWidth-1:0]    DataOut,
   output logic                 DataOutValid,
   input  logic                 DataOutReady
);

   localparam int CmdW   = DDRCWidth + MemDepthLog + TimerWidth;
   localparam int WdW    = MWidth + DWidth;
   localparam int BufLog = $clog2(CmdBufDepth);
   localparam int Rows   = 1 << MemDepthLog;

   state_e                 state_q, state_d;
   logic [MemDepthLog-1:0] sweep_q, sweep_d;
   logic [TimerWidth-1:0]  timer_q;
   logic [7:0]             credit_q, credit_d;
   logic                   head_ripe_q, head_ripe_d;
   logic                   rd_pend_q;
   logic [DWidth-1:0]      rd_data_q;
   logic [DWidth-1:0]      mem_q [Rows];

   logic [DWidth-1:0] ob_q [2];
   logic              ob_wr_q, ob_rd_q;
   logic [1:0]        ob_cnt_q;

   logic                   run, cmd_acc, cmd_vld, wd_acc, wd_vld;
   logic [CmdW-1:0]        cmd_in, head;
   logic [WdW-1:0]         wd_head;
   logic [DDRCWidth-1:0]   head_cmd;
   logic [MemDepthLog-1:0] head_row;
   logic [TimerWidth-1:0]  head_ts, age;
   logic                   is_wr, is_rd, is_other, ripe, wr_retire, rd_issue, head_pop;
   logic                   ob_pop, ob_space;
   logic [2:0]             ob_occ;
   logic                   mem_we;
   logic [MWidth-1:0]      mem_be;
   logic [MemDepthLog-1:0] mem_waddr;
   logic [DWidth-1:0]      mem_wdata;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^CommandAddress;

   assign run          = (state_q == ST_RUN);
   assign CommandReady = run & cmd_acc;
   assign DataInReady  = run & wd_acc;
   assign cmd_in       = {Command, CommandAddress[AddrShift +: MemDepthLog], timer_q};

   throttled_dram_model_fiforam #(.Width(CmdW), .DepthLog(BufLog)) u_cmd_fifo (
      .Clock(Clock), .Reset(Reset),
      .InData(cmd_in), .InValid(CommandValid & run), .InAccept(cmd_acc),
      .OutData(head), .OutSend(cmd_vld), .OutReady(head_pop)
   );

   throttled_dram_model_fiforam #(.Width(WdW), .DepthLog(BufLog)) u_wd_fifo (
      .Clock(Clock), .Reset(Reset),
      .InData({DataInMask, DataIn}), .InValid(DataInValid & run), .InAccept(wd_acc),
      .OutData(wd_head), .OutSend(wd_vld), .OutReady(wr_retire)
   );

   // Head decode: one in-order retire per cycle keeps reads coherent with earlier writes.
   assign head_cmd  = head[CmdW-1 -: DDRCWidth];
   assign head_row  = head[TimerWidth +: MemDepthLog];
   assign head_ts   = head[TimerWidth-1:0];
   assign age       = timer_q - head_ts;
   assign is_wr     = cmd_vld & (head_cmd == DDR3CMD_Write);
   assign is_rd     = cmd_vld & (head_cmd == DDR3CMD_Read);
   assign is_other  = cmd_vld & ~is_wr & ~is_rd;
   assign ripe      = head_ripe_q | (age >= TimerWidth'(OutInitLat));

   // Space counts the beat already in the BRAM read stage so the buffer cannot overflow.
   assign ob_pop    = DataOutValid & DataOutReady;
   assign ob_occ    = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, ob_pop};
   assign ob_space  = (ob_occ < 3'd2);

   assign wr_retire = is_wr & wd_vld;
   assign rd_issue  = is_rd & ripe & (credit_q >= CreditFull) & ob_space;
   assign head_pop  = wr_retire | rd_issue | is_other;

   assign credit_d    = credit_next(credit_q, rd_issue, 8'(OutBandWidth));
   assign head_ripe_d = head_pop ? 1'b0 : (head_ripe_q | (is_rd & ripe));

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (state_q == ST_INIT) begin
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == {MemDepthLog{1'b1}}) state_d = ST_RUN;
      end
   end

   always_comb begin
      mem_we    = wr_retire;
      mem_be    = ~wd_head[WdW-1 -: MWidth];
      mem_waddr = head_row;
      mem_wdata = wd_head[DWidth-1:0];
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_be    = '1;
         mem_waddr = sweep_q;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= ST_INIT;
         sweep_q     <= '0;
         timer_q     <= '0;
         credit_q    <= CreditFull;
         head_ripe_q <= 1'b0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sweep_q     <= sweep_d;
         timer_q     <= timer_q + 1'b1;
         credit_q    <= credit_d;
         head_ripe_q <= head_ripe_d;
         rd_pend_q   <= rd_issue;
      end
   end

   always_ff @(posedge Clock) begin
      for (int b = 0; b < MWidth; b++) begin
         if (mem_we && mem_be[b]) mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
      if (rd_issue) rd_data_q <= mem_q[head_row];
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         ob_q[0]  <= '0;
         ob_q[1]  <= '0;
         ob_wr_q  <= 1'b0;
         ob_rd_q  <= 1'b0;
         ob_cnt_q <= 2'd0;
      end else begin
         if (rd_pend_q) begin
            ob_q[ob_wr_q] <= rd_data_q;
            ob_wr_q       <= ~ob_wr_q;
         end
         if (ob_pop) ob_rd_q <= ~ob_rd_q;
         ob_cnt_q <= ob_cnt_q + {1'b0, rd_pend_q} - {1'b0, ob_pop};
      end
   end

   assign DataOutValid = (ob_cnt_q != 2'd0);
   assign DataOut      = ob_q[ob_rd_q];

endmodule

// File: tb/tb_throttled_dram_model.sv
// Randomized and directed bench for throttled_dram_model against a behavioural
// memory/queue reference model.
module tb_throttled_dram_model;
   import throttled_dram_model_pkg::*;

   localparam int AW   = 31;
   localparam int DW   = 64;
   localparam int MW   = 8;
   localparam int MDL  = 4;
   localparam int ROWS = 16;
   localparam int LAT  = 30;
   localparam int BW   = 50;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [AW-1:0]        CommandAddress = '0;
   logic [DDRCWidth-1:0] Command = '0;
   logic                 CommandValid = 1'b0;
   logic                 CommandReady;
   logic [DW-1:0]        DataIn = '0;
   logic [MW-1:0]        DataInMask = '0;
   logic                 DataInValid = 1'b0;
   logic                 DataInReady;
   logic [DW-1:0]        DataOut;
   logic                 DataOutValid;
   logic                 DataOutReady = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int nbeats = 0;
   int rdy_mode = 0;
   bit mon_reset = 1'b0;
   logic [DW-1:0] model_mem [ROWS];
   logic [DW-1:0] expq [$];
   int beat_cyc [$];

   throttled_dram_model #(
      .AWidth(AW), .DWidth(DW), .MWidth(MW), .AddrShift(3), .MemDepthLog(MDL),
      .CmdBufDepth(8), .OutInitLat(LAT), .OutBandWidth(BW), .TimerWidth(16)
   ) u_dut (
      .Clock(clk), .Reset(rst),
      .CommandAddress(CommandAddress), .Command(Command),
      .CommandValid(CommandValid), .CommandReady(CommandReady),
      .DataIn(DataIn), .DataInMask(DataInMask),
      .DataInValid(DataInValid), .DataInReady(DataInReady),
      .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic monitor_loop();
      logic [DW-1:0] held = '0;
      logic [DW-1:0] e;
      bit stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (rst || mon_reset) begin
            stalled   = 1'b0;
            mon_reset = 1'b0;
         end else begin
            if (stalled) begin
               check_eq("hold_valid", 64'(DataOutValid), 64'd1);
               check_eq("hold_stable", DataOut, held);
            end
            if (DataOutValid && DataOutReady) begin
               if (expq.size() == 0) check_eq("unexpected_beat", 64'(expq.size()), 64'd1);
               else begin
                  e = expq.pop_front();
                  check_eq("rdata", DataOut, e);
                  beat_cyc.push_back(cyc);
                  nbeats++;
               end
            end
            stalled = DataOutValid && !DataOutReady;
            held    = DataOut;
         end
      end
   endtask

   task automatic ready_loop();
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       DataOutReady = 1'b0;
            1:       DataOutReady = 1'b1;
            default: DataOutReady = 1'($urandom_range(0, 1));
         endcase
      end
   endtask

   task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] addr, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input int budget, input bit must,
                         output bit ok, output int t_acc);
      int row;
      ok = 1'b0;
      t_acc = -1;
      Command = c;
      CommandAddress = addr;
      CommandValid = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (CommandReady) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            t_acc = cyc;
            break;
         end
      end
      CommandValid = 1'b0;
      if (must) check_eq("cmd_accept", 64'(ok), 64'd1);
      row = int'(addr[3 +: MDL]);
      if (ok && c == DDR3CMD_Write) begin
         for (int b = 0; b < MW; b++) if (!m[b]) model_mem[row][b*8 +: 8] = d[b*8 +: 8];
      end else if (ok && c == DDR3CMD_Read) begin
         expq.push_back(model_mem[row]);
      end
   endtask

   task automatic do_wdata(input logic [DW-1:0] d, input logic [MW-1:0] m);
      bit ok = 1'b0;
      DataIn = d;
      DataInMask = m;
      DataInValid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (DataInReady) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      DataInValid = 1'b0;
      check_eq("wdata_accept", 64'(ok), 64'd1);
   endtask

   task automatic write_row(input int row, input logic [DW-1:0] d, input logic [MW-1:0] m);
      bit ok;
      int t;
      do_wdata(d, m);
      do_cmd(DDR3CMD_Write, AW'(row << 3), d, m, 2000, 1'b1, ok, t);
   endtask

   task automatic read_addr(input logic [AW-1:0] a, output int t);
      bit ok;
      do_cmd(DDR3CMD_Read, a, '0, '0, 2000, 1'b1, ok, t);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (expq.size() == 0) break;
      end
      #1;
      check_eq(tag, 64'(expq.size()), 64'd0);
   endtask

   task automatic reset_and_count(input string tag);
      int n = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_reset = 1'b1;
      expq.delete();
      for (int r = 0; r < ROWS; r++) model_mem[r] = '0;
      check_eq({tag, "_rst_cmdready"}, 64'(CommandReady), 64'd0);
      check_eq({tag, "_rst_dinready"}, 64'(DataInReady), 64'd0);
      check_eq({tag, "_rst_doutvalid"}, 64'(DataOutValid), 64'd0);
      check_eq({tag, "_rst_dout"}, DataOut, 64'd0);
      rst = 1'b0;
      for (n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         if (CommandReady) break;
      end
      check_eq({tag, "_init_cycles"}, 64'(n), 64'(ROWS));
      check_eq({tag, "_dinready_run"}, 64'(DataInReady), 64'd1);
   endtask

   initial begin
      int t, lat, acc, start, left, n0;
      bit ok;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      for (int r = 0; r < ROWS; r++) model_mem[r] = '1;
      fork
         monitor_loop();
         ready_loop();
      join_none

      // Power-up sweep and zero readback
      reset_and_count("boot");
      rdy_mode = 1;
      read_addr('0, t);
      wait_drain("zero_read_drain", 200);

      // Latency of a single read after a write
      write_row(1, {8{8'hA5}}, 8'h00);
      read_addr(AW'(32'h8), t);
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (DataOutValid) begin
            lat = cyc - t;
            break;
         end
      end
      check_eq("rd_latency", 64'(lat), 64'(LAT + 1));
      wait_drain("latency_drain", 100);

      // Byte mask: low 4 bytes written with zero, rest keep all-ones
      write_row(2, '1, 8'h00);
      write_row(2, '0, 8'hF0);
      read_addr(AW'(32'h10), t);
      wait_drain("mask_drain", 200);

      // Throttle: 8 back-to-back reads, credit refill of 50 allows one issue per 2 cycles
      for (int r = 3; r < ROWS; r++) write_row(r, {$urandom, $urandom}, 8'h00);
      beat_cyc.delete();
      for (int r = 3; r < 11; r++) read_addr(AW'(r << 3), t);
      wait_drain("thr_drain", 400);
      check_eq("thr_beats", 64'(beat_cyc.size()), 64'd8);
      for (int i = 1; i < beat_cyc.size(); i++) check_eq("thr_gap", 64'(beat_cyc[i] - beat_cyc[i-1]), 64'd2);
      if (beat_cyc.size() == 8) check_eq("thr_span", 64'(beat_cyc[7] - beat_cyc[0]), 64'd14);

      // Backpressure: 12 reads with DataOutReady held low for 200 cycles
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      start = cyc;
      acc = 0;
      for (int k = 0; k < 12; k++) begin
         left = 200 - (cyc - start);
         if (left < 1) left = 1;
         do_cmd(DDR3CMD_Read, AW'((4 + k) << 3), '0, '0, left, 1'b0, ok, t);
         if (!ok) break;
         acc++;
      end
      check_eq("bp_absorbed", 64'(acc), 64'd10);
      check_eq("bp_cmdready_low", 64'(CommandReady), 64'd0);
      n0 = nbeats;
      rdy_mode = 1;
      for (int k = acc; k < 12; k++) do_cmd(DDR3CMD_Read, AW'((4 + k) << 3), '0, '0, 2000, 1'b1, ok, t);
      wait_drain("bp_drain", 1000);
      check_eq("bp_beats", 64'(nbeats - n0), 64'd12);

      // Reset with reads outstanding
      rdy_mode = 0;
      for (int k = 0; k < 5; k++) read_addr(AW'((5 + k) << 3), t);
      repeat (40) @(posedge clk);
      #1;
      check_eq("pre_rst_valid", 64'(DataOutValid), 64'd1);
      reset_and_count("midrst");
      rdy_mode = 1;
      n0 = nbeats;
      repeat (60) @(posedge clk);
      #1;
      check_eq("no_stale_beats", 64'(nbeats - n0), 64'd0);
      read_addr(AW'(5 << 3), t);
      wait_drain("post_rst_drain", 200);
      check_eq("post_rst_beats", 64'(nbeats - n0), 64'd1);

      // Random mix of writes, reads and unknown commands with random backpressure
      rdy_mode = 2;
      for (int k = 0; k < 300; k++) begin
         int r = $urandom_range(0, 9);
         a = AW'($urandom);
         d = {$urandom, $urandom};
         m = MW'($urandom);
         if (r < 4) begin
            if ($urandom_range(0, 1) == 1) begin
               do_wdata(d, m);
               do_cmd(DDR3CMD_Write, a, d, m, 2000, 1'b1, ok, t);
            end else begin
               do_cmd(DDR3CMD_Write, a, d, m, 2000, 1'b1, ok, t);
               do_wdata(d, m);
            end
         end else if (r < 9) begin
            do_cmd(DDR3CMD_Read, a, '0, '0, 2000, 1'b1, ok, t);
         end else begin
            do_cmd(3'($urandom_range(2, 7)), a, '0, '0, 2000, 1'b1, ok, t);
         end
      end
      wait_drain("rand_drain", 5000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
